// File: rtl/axi_line_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_line_adapter_pkg
// Brief  : Shared types, AXI encodings and helpers for axi_line_adapter.
// Rev    : 1.0  initial release
// ============================================================================
package axi_line_adapter_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_ID_W   = 4;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] CACHE_MOD   = 4'b0010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WR_B  = 3'd2,
    RD_AR = 3'd3,
    RD_R  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
  } ax_chan_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_DATA_W/8-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0] id;
    logic [1:0]          resp;
  } b_chan_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

  // Index of the beat holding addr within its line.
  function automatic int unsigned beat_index(input logic [63:0] addr,
                                             input int unsigned line_bytes,
                                             input int unsigned beat_bytes);
    logic [63:0] offs;
    offs = addr % 64'(line_bytes);
    return 32'(offs / 64'(beat_bytes));
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_line_adapter.sv
`default_nettype none
// ============================================================================
// Module : axi_line_adapter
// Brief  : Converts one cache request (word or full line) into one AXI4 burst.
//          Optional macro AXI_LINE_ADAPTER_CWF_EN: critical-word-first line reads.
// Rev    : 1.0  initial release
// ============================================================================
module axi_line_adapter
  import axi_line_adapter_pkg::*;
#(
  parameter int unsigned LINE_WIDTH     = 256,
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter type axi_req_t = axi_line_adapter_pkg::axi_req_t,
  parameter type axi_rsp_t = axi_line_adapter_pkg::axi_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      line_i,
  input  logic                      we_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]                size_i,
  input  logic [AXI_ID_WIDTH-1:0]   id_i,
  input  logic [LINE_WIDTH-1:0]     wdata_i,
  input  logic [LINE_WIDTH/8-1:0]   be_i,
  output logic                      valid_o,
  output logic [LINE_WIDTH-1:0]     rdata_o,
  output logic [AXI_ID_WIDTH-1:0]   id_o,
  output logic                      err_o,
  output logic                      cw_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] cw_o,
  output axi_req_t                  axi_req_o,
  input  axi_rsp_t                  axi_resp_i
);

  localparam int unsigned NUM_BEATS  = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned LINE_BYTES = LINE_WIDTH / 8;
  localparam int unsigned STRB_W     = AXI_DATA_WIDTH / 8;
  localparam logic [2:0]  LINE_SIZE  = 3'($clog2(BEAT_BYTES));
  localparam logic [7:0]  LINE_LEN   = 8'(NUM_BEATS - 1);
  localparam logic [CNT_W:0] NB_EXT  = (CNT_W + 1)'(NUM_BEATS);
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = ~(AXI_ADDR_WIDTH'(LINE_BYTES - 1));
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK = ~(AXI_ADDR_WIDTH'(BEAT_BYTES - 1));

  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_inc;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [LINE_WIDTH-1:0]     line_buf, line_next, rdata_q;
  logic [LINE_WIDTH/8-1:0]   be_q;
  logic                      is_line, err_q, aw_done, w_done, rd_done;
  logic [2:0]                size_q;

  logic             aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic             aw_hs, w_hs, r_hs, w_last, b_fire;
  logic [7:0]       len;
  logic [CNT_W-1:0] addr_beat, start_beat, w_beat, slot;
  logic [CNT_W:0]   slot_sum;

  generate
    if (NUM_BEATS == 1) begin : g_cnt_tied
      assign cnt_inc = '0;
    end else begin : g_cnt_inc
      assign cnt_inc = cnt + 1'b1;
    end
  endgenerate

  assign addr_beat = CNT_W'(beat_index(64'(addr_q), LINE_BYTES, BEAT_BYTES));

`ifdef AXI_LINE_ADAPTER_CWF_EN
  assign start_beat = addr_beat;
`else
  assign start_beat = is_line ? '0 : addr_beat;
`endif

  assign w_beat   = is_line ? cnt : addr_beat;
  assign slot_sum = {1'b0, start_beat} + {1'b0, cnt};
  assign slot     = (slot_sum >= NB_EXT) ? CNT_W'(slot_sum - NB_EXT) : slot_sum[CNT_W-1:0];
  assign len      = is_line ? LINE_LEN : 8'd0;
  assign w_last   = (8'(cnt) == len);

  assign aw_hs  = aw_valid & axi_resp_i.aw_ready;
  assign w_hs   = w_valid & axi_resp_i.w_ready;
  assign r_hs   = r_ready & axi_resp_i.r_valid;
  assign b_fire = b_ready & axi_resp_i.b_valid;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (req_i) state_n = we_i ? WR : RD_AR;
      WR:    if ((aw_done || aw_hs) && (w_done || (w_hs && w_last))) state_n = WR_B;
      WR_B:  if (axi_resp_i.b_valid) state_n = IDLE;
      RD_AR: if (axi_resp_i.ar_ready) state_n = RD_R;
      RD_R:  if (axi_resp_i.r_valid && axi_resp_i.r.last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_o    = 1'b0;
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    ar_valid = 1'b0;
    r_ready  = 1'b0;
    unique case (state)
      IDLE:  gnt_o = req_i;
      WR: begin
        aw_valid = !aw_done;
        w_valid  = !w_done;
      end
      WR_B:  b_ready  = 1'b1;
      RD_AR: ar_valid = 1'b1;
      RD_R:  r_ready  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    line_next = line_buf;
    line_next[slot*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = axi_resp_i.r.data;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt      <= '0;
      addr_q   <= '0;
      id_q     <= '0;
      line_buf <= '0;
      be_q     <= '0;
      is_line  <= 1'b0;
      size_q   <= '0;
      err_q    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rd_done  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_done <= 1'b0;
      if (gnt_o) begin
        addr_q   <= addr_i;
        id_q     <= id_i;
        line_buf <= we_i ? wdata_i : '0;
        be_q     <= be_i;
        is_line  <= line_i;
        size_q   <= size_i;
        err_q    <= 1'b0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        cnt      <= '0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) begin
        cnt <= cnt_inc;
        if (w_last) w_done <= 1'b1;
      end
      if (r_hs) begin
        cnt      <= cnt_inc;
        line_buf <= line_next;
        err_q    <= err_q | axi_resp_i.r.resp[1];
        if (axi_resp_i.r.last) begin
          rdata_q <= line_next;
          rd_done <= 1'b1;
        end
      end
    end
  end

  // Write completion is reported combinationally with B; read completion one cycle after r_last.
  assign valid_o    = b_fire | rd_done;
  assign err_o      = rd_done ? err_q : (b_fire & axi_resp_i.b.resp[1]);
  assign id_o       = id_q;
  assign rdata_o    = rdata_q;
  assign cw_valid_o = r_hs && (cnt == '0);
  assign cw_o       = axi_resp_i.r.data;

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw.id    = id_q;
    axi_req_o.aw.addr  = is_line ? (addr_q & LINE_MASK) : addr_q;
    axi_req_o.aw.len   = len;
    axi_req_o.aw.size  = is_line ? LINE_SIZE : size_q;
    axi_req_o.aw.burst = BURST_INCR;
    axi_req_o.aw.cache = CACHE_MOD;
    axi_req_o.aw_valid = aw_valid;
    axi_req_o.w.data   = line_buf[w_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    axi_req_o.w.strb   = be_q[w_beat*STRB_W +: STRB_W];
    axi_req_o.w.last   = w_last;
    axi_req_o.w_valid  = w_valid;
    axi_req_o.b_ready  = b_ready;
    axi_req_o.ar.id    = id_q;
`ifdef AXI_LINE_ADAPTER_CWF_EN
    axi_req_o.ar.addr  = is_line ? (addr_q & BEAT_MASK) : addr_q;
    axi_req_o.ar.burst = is_line ? BURST_WRAP : BURST_INCR;
`else
    axi_req_o.ar.addr  = is_line ? (addr_q & LINE_MASK) : addr_q;
    axi_req_o.ar.burst = BURST_INCR;
`endif
    axi_req_o.ar.len   = len;
    axi_req_o.ar.size  = is_line ? LINE_SIZE : size_q;
    axi_req_o.ar.cache = CACHE_MOD;
    axi_req_o.ar_valid = ar_valid;
    axi_req_o.r_ready  = r_ready;
  end

  logic unused_rsp;
  assign unused_rsp = ^{axi_resp_i.b.id, axi_resp_i.b.resp[0],
                        axi_resp_i.r.id, axi_resp_i.r.resp[0], BEAT_MASK};

endmodule
`default_nettype wire

// File: tb/tb_axi_line_adapter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_line_adapter
// Brief  : Directed + randomized bench with an AXI slave model for axi_line_adapter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_line_adapter;
  import axi_line_adapter_pkg::*;

  localparam int LW = 256;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int NB = LW / DW;
`ifdef AXI_LINE_ADAPTER_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, req, gnt, line, we, valid, err, cw_valid;
  logic [AW-1:0]   addr;
  logic [2:0]      size;
  logic [IW-1:0]   id, id_out;
  logic [LW-1:0]   wdata, rdata;
  logic [LW/8-1:0] be;
  logic [DW-1:0]   cw;
  axi_req_t        axi_req;
  axi_rsp_t        axi_rsp;

  axi_line_adapter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .line_i(line), .we_i(we),
    .addr_i(addr), .size_i(size), .id_i(id), .wdata_i(wdata), .be_i(be),
    .valid_o(valid), .rdata_o(rdata), .id_o(id_out), .err_o(err),
    .cw_valid_o(cw_valid), .cw_o(cw), .axi_req_o(axi_req), .axi_resp_i(axi_rsp)
  );

  int vectors = 0;
  int miscompares = 0;

  // Slave model state
  typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } rbeat_t;
  rbeat_t      rq[$];
  logic [DW-1:0] wd_q[$];
  logic [7:0]    ws_q[$];
  logic          wl_q[$];
  ax_chan_t    aw_cap, ar_cap;
  logic        aw_seen, w_last_seen, b_pend, aw_hold, b_err;
  int          w_before_aw, cw_pulses, ready_pct, err_beat;
  logic [DW-1:0] cw_seen;
  logic [31:0] salt;

  function automatic bit rnd(input int pct);
    return $urandom_range(99) < pct;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [63:0] a);
    return {salt, a[31:0]};
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_clear();
    rq.delete();
    axi_rsp     = '0;
    aw_seen     = 1'b0;
    w_last_seen = 1'b0;
    b_pend      = 1'b0;
  endtask

  always @(negedge clk) begin
    axi_rsp.aw_ready = rnd(ready_pct) && !(aw_hold && !w_last_seen);
    axi_rsp.w_ready  = rnd(ready_pct);
    axi_rsp.ar_ready = rnd(ready_pct);
    axi_rsp.b_valid  = b_pend && rnd(ready_pct);
    axi_rsp.b.id     = aw_cap.id;
    axi_rsp.b.resp   = b_err ? RESP_SLVERR : 2'b00;
    axi_rsp.r_valid  = (rq.size() > 0) && rnd(ready_pct);
    axi_rsp.r        = '0;
    if (rq.size() > 0) begin
      axi_rsp.r.id   = ar_cap.id;
      axi_rsp.r.data = rq[0].data;
      axi_rsp.r.resp = rq[0].resp;
      axi_rsp.r.last = rq[0].last;
    end
    #1;
    if (axi_rsp.b_valid && axi_req.b_ready) begin
      aw_seen = 1'b0; w_last_seen = 1'b0; b_pend = 1'b0;
    end
    if (axi_req.aw_valid && axi_rsp.aw_ready) begin
      aw_cap = axi_req.aw; aw_seen = 1'b1; w_before_aw = wd_q.size();
    end
    if (axi_req.w_valid && axi_rsp.w_ready) begin
      wd_q.push_back(axi_req.w.data);
      ws_q.push_back(axi_req.w.strb);
      wl_q.push_back(axi_req.w.last);
      if (axi_req.w.last) w_last_seen = 1'b1;
    end
    if (aw_seen && w_last_seen) b_pend = 1'b1;
    if (axi_req.ar_valid && axi_rsp.ar_ready) begin
      logic [63:0] bytes, wrapb, base, a;
      int n;
      ar_cap = axi_req.ar;
      n      = int'(ar_cap.len) + 1;
      bytes  = 64'd1 << ar_cap.size;
      wrapb  = 64'(n) * bytes;
      base   = ar_cap.addr & ~(wrapb - 64'd1);
      for (int k = 0; k < n; k++) begin
        rbeat_t bt;
        if (ar_cap.burst == BURST_WRAP)
          a = base + ((ar_cap.addr - base + 64'(k) * bytes) % wrapb);
        else
          a = (ar_cap.addr & ~(bytes - 64'd1)) + 64'(k) * bytes;
        bt.data = data_of(a & ~64'd7);
        bt.resp = (k == err_beat) ? RESP_SLVERR : 2'b00;
        bt.last = (k == n - 1);
        rq.push_back(bt);
      end
    end
    if (cw_valid) begin
      cw_pulses++;
      cw_seen = cw;
    end
    if (axi_rsp.r_valid && axi_req.r_ready) void'(rq.pop_front());
  end

  task automatic run_txn(input bit l, input bit w, input logic [63:0] a, input logic [2:0] sz);
    logic [IW-1:0]   tid;
    logic [LW-1:0]   td, exp_line;
    logic [LW/8-1:0] tbe;
    logic [DW-1:0]   exp_cw;
    logic [63:0]     lbase, exp_addr;
    logic            exp_err;
    bit              got;
    int              bi, n;
    tid = IW'($urandom);
    for (int k = 0; k < LW / 32; k++) td[k*32 +: 32] = $urandom;
    for (int k = 0; k < LW / 8; k++) tbe[k] = 1'($urandom_range(1));
    salt = $urandom;
    wd_q.delete(); ws_q.delete(); wl_q.delete();
    cw_pulses = 0; w_before_aw = -1;

    @(negedge clk);
    req = 1'b1; line = l; we = w; addr = a; size = sz; id = tid; wdata = td; be = tbe;
    #2; check("gnt", LW'(gnt), LW'(1));
    @(negedge clk);
    req = 1'b0; addr = {$urandom, $urandom}; wdata = '1; be = '0; id = ~tid;
    line = ~l; we = ~w; size = ~sz;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      #2;
      if (valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("completion_timeout", LW'(got), LW'(1));

    bi      = int'(a[4:0]) / 8;
    lbase   = a & ~64'(LW / 8 - 1);
    n       = l ? NB : 1;
    exp_err = w ? b_err : (err_beat >= 0 && err_beat < n);
    check("id_o", LW'(id_out), LW'(tid));
    check("err_o", LW'(err), LW'(exp_err));
    if (!w) begin
      exp_line = '0;
      if (l) for (int j = 0; j < NB; j++) exp_line[j*DW +: DW] = data_of(lbase + 64'(j * 8));
      else   exp_line[bi*DW +: DW] = data_of(a & ~64'd7);
      exp_cw   = (l && !CWF) ? data_of(lbase) : data_of(a & ~64'd7);
      exp_addr = l ? (CWF ? (a & ~64'd7) : lbase) : a;
      check("rdata_o", rdata, exp_line);
      check("cw_o", LW'(cw_seen), LW'(exp_cw));
      check("cw_valid_pulses", LW'(cw_pulses), LW'(1));
      check("ar_fields",
            LW'({ar_cap.addr, ar_cap.len, ar_cap.size, ar_cap.burst, ar_cap.cache, ar_cap.lock, ar_cap.prot, ar_cap.qos}),
            LW'({exp_addr, 8'(n - 1), l ? 3'd3 : sz, (l && CWF) ? 2'b10 : 2'b01, 4'b0010, 1'b0, 3'b0, 4'b0}));
    end else begin
      exp_addr = l ? lbase : a;
      check("aw_fields",
            LW'({aw_cap.addr, aw_cap.len, aw_cap.size, aw_cap.burst, aw_cap.cache, aw_cap.lock, aw_cap.prot, aw_cap.qos}),
            LW'({exp_addr, 8'(n - 1), l ? 3'd3 : sz, 2'b01, 4'b0010, 1'b0, 3'b0, 4'b0}));
      check("w_beat_count", LW'(wd_q.size()), LW'(n));
      for (int k = 0; k < n && k < wd_q.size(); k++) begin
        int s;
        s = l ? k : bi;
        check("w_beat", LW'({wd_q[k], ws_q[k], wl_q[k]}),
              LW'({td[s*DW +: DW], tbe[s*8 +: 8], k == n - 1}));
      end
      check("cw_valid_on_write", LW'(cw_pulses), LW'(0));
    end
    @(negedge clk); #2;
    check("valid_one_cycle", LW'(valid), LW'(0));
  endtask

  initial begin
    bit got;
    req = 0; line = 0; we = 0; addr = '0; size = '0; id = '0; wdata = '0; be = '0;
    ready_pct = 100; aw_hold = 0; b_err = 0; err_beat = -1; salt = '0;
    cw_pulses = 0; w_before_aw = -1; cw_seen = '0;
    aw_cap = '0; ar_cap = '0;
    slave_clear();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_flags", LW'({gnt, valid, err, cw_valid}), LW'(0));
    check("rst_rdata", rdata, '0);
    check("rst_id", LW'(id_out), LW'(0));
    check("rst_axi_valids",
          LW'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready}), LW'(0));
    rst_n = 1'b1;

    run_txn(1, 0, 64'h1000, 3'd3);
    aw_hold = 1;
    run_txn(1, 1, 64'h1000, 3'd3);
    check("w_before_aw", LW'(w_before_aw), LW'(4));
    aw_hold = 0;
    run_txn(0, 1, 64'h1018, 3'd3);
    err_beat = 2;
    run_txn(1, 0, 64'h1040, 3'd3);
    err_beat = -1;
    run_txn(1, 0, 64'h1080, 3'd3);
    run_txn(1, 0, 64'h1010, 3'd3);
    b_err = 1;
    run_txn(1, 1, 64'h10C0, 3'd3);
    b_err = 0;

    // Reset while the read data phase is in progress.
    ready_pct = 25; salt = $urandom;
    @(negedge clk);
    req = 1; line = 1; we = 0; addr = 64'h2000; size = 3'd3;
    #2; check("gnt_before_reset", LW'(gnt), LW'(1));
    @(negedge clk);
    req = 0;
    got = 0;
    for (int c = 0; c < 300; c++) begin
      #2;
      if (axi_req.r_ready) begin got = 1; break; end
      @(negedge clk);
    end
    check("reach_rd_r", LW'(got), LW'(1));
    rst_n = 1'b0;
    slave_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("mid_rst_flags", LW'({gnt, valid, err, cw_valid}), LW'(0));
    check("mid_rst_rdata", rdata, '0);
    check("mid_rst_id", LW'(id_out), LW'(0));
    check("mid_rst_axi_valids",
          LW'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid, axi_req.r_ready}), LW'(0));
    ready_pct = 100;
    run_txn(0, 0, 64'h1008, 3'd3);

    for (int t = 0; t < 40; t++) begin
      ready_pct = $urandom_range(30, 100);
      aw_hold   = ($urandom_range(3) == 0);
      b_err     = ($urandom_range(3) == 0);
      err_beat  = ($urandom_range(2) == 0) ? int'($urandom_range(NB - 1)) : -1;
      run_txn(1'($urandom_range(1)), 1'($urandom_range(1)),
              64'h1000 + 64'($urandom_range(511)), 3'($urandom_range(3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
